// File: rtl/detect_seq_ctrl_pkg.sv
// Shared types for the "1101" detector sequencer.
// Holds the controller state encoding and detector timing.
package detect_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    FETCH,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam int DET_MATCH_LAT = 1;

endpackage

// File: rtl/detect_seq_ctrl_serializer.sv
// MSB-first parallel-to-serial shifter with a bit index.
// A load always wins over a shift so a reload can follow the last bit.
module word_serializer #(
  parameter int  WORD_W = 8,
  localparam int IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              msb_o,
  output logic              last_bit_o
);

  logic [WORD_W-1:0] sreg_q;
  logic [IDX_W-1:0]  idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
      idx_q  <= '0;
    end else if (shift_i) begin
      sreg_q <= sreg_q << 1;
      idx_q  <= idx_q + 1'b1;
    end
  end

  assign msb_o      = sreg_q[WORD_W-1];
  assign last_bit_o = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/detect_seq_ctrl.sv
// Frame sequencer feeding a bit-serial "1101" detector.
// Serializes words, clears the detector and counts its matches.
module detect_seq_ctrl
  import detect_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_last,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              det_clr,
  output logic              det_en,
  output logic              det_bit,
  input  logic              det_match,
  output logic              busy,
  output logic [CNT_W-1:0]  match_count,
  output logic              frame_done
);

  ctrl_state_t              state_q;
  logic                     last_q;
  logic [DET_MATCH_LAT-1:0] en_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         cnt_d;
  logic                     xfer;
  logic                     msb;
  logic                     last_bit;

  word_serializer #(
    .WORD_W(WORD_W)
  ) u_ser (
    .clk       (clk),
    .rst       (rst),
    .load_i    (xfer),
    .shift_i   (det_en),
    .data_i    (word_in),
    .msb_o     (msb),
    .last_bit_o(last_bit)
  );

  assign word_ready = (state_q == IDLE) ||
                      (state_q == FETCH) ||
                      (state_q == SHIFT && last_bit && !last_q);
  assign xfer        = word_valid && word_ready;
  assign det_en      = (state_q == SHIFT);
  assign det_clr     = (state_q == CLEAR);
  assign det_bit     = det_en & msb;
  assign busy        = (state_q != IDLE);
  assign frame_done  = (state_q == DONE);
  assign match_count = cnt_q;

  // en_q lines up each det_en with the detector's delayed output
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = '0;
    end else if (en_q[DET_MATCH_LAT-1] && det_match && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      en_q    <= '0;
      cnt_q   <= '0;
    end else begin
      en_q  <= (en_q << 1) | DET_MATCH_LAT'(det_en);
      cnt_q <= cnt_d;
      if (xfer) last_q <= word_last;
      unique case (state_q)
        IDLE:  if (xfer) state_q <= CLEAR;
        CLEAR: state_q <= SHIFT;
        SHIFT: begin
          if (last_bit) begin
            if (last_q)     state_q <= DRAIN;
            else if (!xfer) state_q <= FETCH;
          end
        end
        FETCH: if (xfer) state_q <= SHIFT;
        DRAIN: state_q <= DONE;
        DONE:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
